// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

   // Number of writeback sources sharing the register file write port.
   localparam int unsigned WB_NPORT = 2;

   // Default widths, matching the core's XLEN and register index width.
   localparam int unsigned WB_XLEN_DEF = 32;
   localparam int unsigned WB_IDXW_DEF = 5;

   // Port identity, also used as the round-robin favour pointer.
   typedef enum logic {
      wb_port0 = 1'b0,
      wb_port1 = 1'b1
   } wb_port_e;

endpackage

// File: rtl/rf_wb_slot.sv
// One-entry writeback buffer for a single source port.
// Accepts when empty or when its entry is being granted this cycle; writes to x0
// are consumed without being buffered.
module rf_wb_slot
   import rf_wb_arbiter_pkg::*;
#(
   parameter int unsigned XLEN = WB_XLEN_DEF,
   parameter int unsigned IDXW = WB_IDXW_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid,
   output logic            ready,
   input  logic [IDXW-1:0] idx,
   input  logic [XLEN-1:0] data,
   input  logic            grant,
   output logic            occ,
   output logic [IDXW-1:0] buf_idx,
   output logic [XLEN-1:0] buf_data
);

   logic            occ_q, occ_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [XLEN-1:0] data_q, data_d;
   logic            accept;

   // Grant pass-through lets a port stream one write per cycle.
   assign ready  = !reset && (!occ_q || grant);
   assign accept = valid && ready;

   assign occ      = occ_q;
   assign buf_idx  = idx_q;
   assign buf_data = data_q;

   // Next-state: refill on accept (unless x0), else drain on grant.
   always_comb begin
      occ_d  = occ_q;
      idx_d  = idx_q;
      data_d = data_q;
      if (accept && (idx != '0)) begin
         occ_d  = 1'b1;
         idx_d  = idx;
         data_d = data;
      end else if (grant) begin
         occ_d = 1'b0;
      end
   end

   // Buffer state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q  <= 1'b0;
         idx_q  <= '0;
         data_q <= '0;
      end else begin
         occ_q  <= occ_d;
         idx_q  <= idx_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the integer register file's single write port.
// Two buffered sources, one grant per cycle, registered we3/wa3/wd3 output stage
// and a pending-write mask for hazard detection.
// Build option: define WB_ARB_RR_EN for round-robin arbitration; otherwise port 0
// has fixed priority.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int unsigned XLEN = WB_XLEN_DEF,
   parameter int unsigned IDXW = WB_IDXW_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 p0_valid,
   output logic                 p0_ready,
   input  logic [IDXW-1:0]      p0_idx,
   input  logic [XLEN-1:0]      p0_data,
   input  logic                 p1_valid,
   output logic                 p1_ready,
   input  logic [IDXW-1:0]      p1_idx,
   input  logic [XLEN-1:0]      p1_data,
   output logic                 we3,
   output logic [IDXW-1:0]      wa3,
   output logic [XLEN-1:0]      wd3,
   output logic [2**IDXW-1:0]   pend_mask
);

   logic            occ0, occ1;
   logic [IDXW-1:0] bidx0, bidx1;
   logic [XLEN-1:0] bdata0, bdata1;
   logic            gnt0, gnt1;
   logic            contested;

   logic            we3_q;
   logic [IDXW-1:0] wa3_q;
   logic [XLEN-1:0] wd3_q;

   rf_wb_slot #(
      .XLEN (XLEN),
      .IDXW (IDXW)
   ) u_slot0 (
      .clk      (clk),
      .reset    (reset),
      .valid    (p0_valid),
      .ready    (p0_ready),
      .idx      (p0_idx),
      .data     (p0_data),
      .grant    (gnt0),
      .occ      (occ0),
      .buf_idx  (bidx0),
      .buf_data (bdata0)
   );

   rf_wb_slot #(
      .XLEN (XLEN),
      .IDXW (IDXW)
   ) u_slot1 (
      .clk      (clk),
      .reset    (reset),
      .valid    (p1_valid),
      .ready    (p1_ready),
      .idx      (p1_idx),
      .data     (p1_data),
      .grant    (gnt1),
      .occ      (occ1),
      .buf_idx  (bidx1),
      .buf_data (bdata1)
   );

   assign contested = occ0 && occ1;

`ifdef WB_ARB_RR_EN
   // Port favoured on the next contested cycle; flips after each contested grant.
   wb_port_e rr_q, rr_d;

   // Round-robin grant: uncontested slots win outright, contested follow rr_q.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      rr_d = rr_q;
      if (contested) begin
         gnt0 = (rr_q == wb_port0);
         gnt1 = (rr_q == wb_port1);
         rr_d = (rr_q == wb_port0) ? wb_port1 : wb_port0;
      end else begin
         gnt0 = occ0;
         gnt1 = occ1;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_q <= wb_port0;
      end else begin
         rr_q <= rr_d;
      end
   end
`else
   // Fixed priority grant: port 0 wins contention.
   always_comb begin
      gnt0 = occ0;
      gnt1 = occ1 && !occ0;
   end
`endif

   // Output stage: load the granted entry, else drop we3 and hold address/data.
   always_ff @(posedge clk) begin
      if (reset) begin
         we3_q <= 1'b0;
         wa3_q <= '0;
         wd3_q <= '0;
      end else if (gnt0) begin
         we3_q <= 1'b1;
         wa3_q <= bidx0;
         wd3_q <= bdata0;
      end else if (gnt1) begin
         we3_q <= 1'b1;
         wa3_q <= bidx1;
         wd3_q <= bdata1;
      end else begin
         we3_q <= 1'b0;
      end
   end

   assign we3 = we3_q;
   assign wa3 = wa3_q;
   assign wd3 = wd3_q;

   // Pending mask from buffered and staged writes only (no input paths).
   always_comb begin
      pend_mask = '0;
      if (occ0) begin
         pend_mask[bidx0] = 1'b1;
      end
      if (occ1) begin
         pend_mask[bidx1] = 1'b1;
      end
      if (we3_q) begin
         pend_mask[wa3_q] = 1'b1;
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios followed by random
// traffic, checked against a per-port buffer reference model and a write scoreboard.
// Honours WB_ARB_RR_EN in its reference model.
module tb_rf_wb_arbiter;

   localparam int XLEN = 32;
   localparam int IDXW = 5;
   localparam int NREG = 2 ** IDXW;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            p0_valid = 1'b0, p1_valid = 1'b0;
   logic            p0_ready, p1_ready;
   logic [IDXW-1:0] p0_idx = '0, p1_idx = '0;
   logic [XLEN-1:0] p0_data = '0, p1_data = '0;
   logic            we3;
   logic [IDXW-1:0] wa3;
   logic [XLEN-1:0] wd3;
   logic [NREG-1:0] pend_mask;

   rf_wb_arbiter #(
      .XLEN (XLEN),
      .IDXW (IDXW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .p0_valid  (p0_valid),
      .p0_ready  (p0_ready),
      .p0_idx    (p0_idx),
      .p0_data   (p0_data),
      .p1_valid  (p1_valid),
      .p1_ready  (p1_ready),
      .p1_idx    (p1_idx),
      .p1_data   (p1_data),
      .we3       (we3),
      .wa3       (wa3),
      .wd3       (wd3),
      .pend_mask (pend_mask)
   );

   always #5 clk = ~clk;

   typedef struct {
      int              due;
      logic [IDXW-1:0] idx;
      logic [XLEN-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;

   // Reference model: what each port currently holds, plus the last issued write.
   bit              m_v[2];
   logic [IDXW-1:0] m_i[2];
   logic [XLEN-1:0] m_d[2];
   int              m_fav = 0;
   bit              m_we = 0;
   logic [IDXW-1:0] m_wa = '0;
   logic [XLEN-1:0] m_wd = '0;
   logic [XLEN-1:0] regfile[NREG];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: every write pulse must match the oldest expected write, on time.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("we3_pulse", {63'b0, we3}, 64'd1);
            chk("wa3", {59'b0, wa3}, {59'b0, exp_q[0].idx});
            chk("wd3", {32'b0, wd3}, {32'b0, exp_q[0].data});
            regfile[wa3] = wd3;
            void'(exp_q.pop_front());
         end else if (we3 === 1'b1) begin
            chk("stray_we3", {59'b0, wa3}, 64'hffff_ffff_ffff_ffff);
         end
      end
   end

   // One clock cycle: check registered outputs, drive inputs, check ready, step model.
   task automatic cycle(input bit rst, input bit v0, input int i0, input logic [31:0] d0,
                        input bit v1, input int i1, input logic [31:0] d1);
      bit              rdy[2];
      bit              gnt[2];
      bit              vv[2];
      logic [IDXW-1:0] ii[2];
      logic [XLEN-1:0] dd[2];
      logic [NREG-1:0] pm;
      int              win;
      @(negedge clk);
      #1;
      pm = '0;
      for (int r = 0; r < NREG; r++) begin
         if ((m_v[0] && m_i[0] == r) || (m_v[1] && m_i[1] == r) || (m_we && m_wa == r))
            pm[r] = 1'b1;
      end
      chk("pend_mask", {32'b0, pend_mask}, {32'b0, pm});
      chk("out_stage", {m_we ? 1'b1 : 1'b0, 26'b0, wa3, wd3}, {we3, 26'b0, m_wa, m_wd});
      reset    = rst;
      p0_valid = v0; p0_idx = i0[IDXW-1:0]; p0_data = d0;
      p1_valid = v1; p1_idx = i1[IDXW-1:0]; p1_data = d1;
      vv[0] = v0; ii[0] = i0[IDXW-1:0]; dd[0] = d0;
      vv[1] = v1; ii[1] = i1[IDXW-1:0]; dd[1] = d1;
      #1;
      // Whoever holds a write is served; a tie goes to the favoured port.
      win = -1;
      if (m_v[0] && m_v[1]) win = m_fav;
      else if (m_v[0]) win = 0;
      else if (m_v[1]) win = 1;
      for (int p = 0; p < 2; p++) begin
         gnt[p] = (win == p);
         rdy[p] = !rst && (!m_v[p] || gnt[p]);
      end
      chk("p0_ready", {63'b0, p0_ready}, {63'b0, rdy[0]});
      chk("p1_ready", {63'b0, p1_ready}, {63'b0, rdy[1]});
      if (rst) begin
         m_v[0] = 0; m_v[1] = 0; m_fav = 0;
         m_we = 0; m_wa = '0; m_wd = '0;
      end else begin
         if (win >= 0) begin
            m_we = 1; m_wa = m_i[win]; m_wd = m_d[win];
            exp_q.push_back('{due: cyc + 1, idx: m_i[win], data: m_d[win]});
`ifdef WB_ARB_RR_EN
            if (m_v[0] && m_v[1]) m_fav = 1 - win;
`endif
         end else begin
            m_we = 0;
         end
         for (int p = 0; p < 2; p++) begin
            if (gnt[p]) m_v[p] = 0;
            if (vv[p] && rdy[p] && ii[p] != 0) begin
               m_v[p] = 1; m_i[p] = ii[p]; m_d[p] = dd[p];
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      for (int r = 0; r < NREG; r++) regfile[r] = '0;
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(1, 1, 3, 32'h33, 1, 4, 32'h44);
      // Single write to x5.
      cycle(0, 1, 5, 32'h1234, 0, 0, 0);
      idle(3);
      // x0 write is consumed silently.
      cycle(0, 0, 0, 0, 1, 0, 32'hffff_ffff);
      idle(3);
      // Contention in one cycle.
      cycle(0, 1, 1, 32'ha, 1, 2, 32'hb);
      idle(3);
      // Port 0 streaming while port 1 waits.
      for (int k = 0; k < 5; k++) cycle(0, 1, 10 + k, 32'h100 + k, 1, 20, 32'h200);
      idle(4);
      // Both ports streaming.
      for (int k = 0; k < 8; k++) cycle(0, 1, 1 + k, 32'h300 + k, 1, 16 + k, 32'h400 + k);
      idle(4);
      // Same destination from both ports: last-granted value must persist.
      cycle(0, 1, 7, 32'h1, 1, 7, 32'h2);
      idle(4);
`ifndef WB_ARB_RR_EN
      chk("x7_final", {32'b0, regfile[7]}, 64'h2);
`endif
      // Reset the cycle after both buffers load.
      cycle(0, 1, 8, 32'h88, 1, 9, 32'h99);
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 11, 32'hbeef, 0, 0, 0);
      idle(3);
      // Random traffic with occasional resets and x0 writes.
      for (int k = 0; k < 600; k++) begin
         cycle($urandom_range(0, 79) == 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom,
               $urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom);
      end
      idle(6);
      chk("drain", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and scheduler for the integer register file. Two writeback sources share the register file's single write port. Port 0 is the in-order pipeline writeback; port 1 is the long-latency unit (multiply/divide or load return). The block buffers one write per source, picks one per cycle, and drives the register file's we3/wa3/wd3 from a registered output stage, so the register file's negedge write sees stable values. It also exports a pending-write mask for the hazard/stall logic.

## Interface
Parameters:
- XLEN, default 32: data width; matches `XLEN.
- IDXW, default 5: register index width; matches `RFIDX_WIDTH.

Ports:
- clk, input, 1: single clock; all state updates on posedge.
- reset, input, 1: synchronous, active-high reset.
- p0_valid, input, 1: port 0 write request.
- p0_ready, output, 1: port 0 can accept this cycle.
- p0_idx, input, IDXW: port 0 destination register.
- p0_data, input, XLEN: port 0 write data.
- p1_valid / p1_ready / p1_idx / p1_data: same as port 0, for port 1.
- we3, output, 1: register file write enable.
- wa3, output, IDXW: register file write address.
- wd3, output, XLEN: register file write data.
- pend_mask, output, 2**IDXW: bit i is set when a write to xi is buffered or in the output stage.

## Operation
- Each port has a one-entry buffer: valid bit, idx and data.
- Ready rule: pN_ready = !reset && (buffer N empty || buffer N granted this cycle). Ready does not depend on pN_valid.
- Accept: pN_valid && pN_ready at posedge. The buffer loads idx and data.
- x0 rule: an accepted request with idx == 0 is consumed. Ready stays per the rule, nothing is buffered, and it never reaches we3 or pend_mask.
- Arbitration is combinational over occupied buffers, with at most one grant per cycle.
  - Only one buffer occupied: that buffer is granted.
  - Both buffers occupied: priority policy decides (see Configuration).
- Grant: the granted buffer clears at posedge, unless refilled by a simultaneous accept on the same port. The output stage loads we3=1, wa3=idx, wd3=data.
- No grant: the output stage loads we3=0. wa3 and wd3 hold their last values.
- Same index from both ports: both writes are performed in grant order, so the last-granted value persists. Consumers must stall on pend_mask; the block does not merge or cancel writes.
- pend_mask is the OR of:
  - the decoded idx of each occupied buffer;
  - the decoded wa3 when we3=1.
  - pend_mask is registered-state-derived and has no combinational path from the inputs.

## Timing
- Cycle k: pN_valid && pN_ready. Posedge end of k: the buffer loads.
- Cycle k+1: the entry is granted, provided it wins arbitration. Posedge end of k+1: the output stage loads.
- Cycle k+2: we3=1 for exactly one cycle. The register file writes at the negedge inside k+2.
- Minimum accept-to-we3 latency is 2 cycles. Each lost arbitration cycle adds 1.
- Throughput: one write per cycle, sustained. A port can accept back-to-back because of the grant pass-through in the ready rule.
- Reset values: we3=0, wa3=0, wd3=0, pend_mask=0, both buffers empty, p0_ready=p1_ready=0 while reset=1, RR pointer=0.
- Reset mid-operation: all buffered and staged writes are dropped. No we3 pulse follows the reset cycle.
- Deassert: ready rises in the first cycle with reset=0.

## Configuration
- WB_ARB_RR_EN undefined: fixed priority, port 0 wins when both buffers are occupied. Port 1 can be starved by continuous port 0 traffic, which is acceptable for the single-cycle/in-order use.
- WB_ARB_RR_EN defined: round-robin between ports.
  - A 1-bit last-grant pointer updates on every contested grant.
  - With the pointer at 0 (the reset value), port 0 is favoured first.
  - After port 0 wins, port 1 wins the next contested cycle.
  - An uncontested grant does not move the pointer.
  - Each port waits at most 1 extra cycle per write.

## Structure
- Width constants (XLEN, RFIDX_WIDTH, RFREG_NUM) come from the shared xgriscv_defines.v. Add a port-count constant `WB_NPORT = 2 there.
- One sub-module, rf_wb_slot: the per-port one-entry buffer (valid/idx/data, x0 drop, ready generation). It is instantiated twice.
- Arbitration, RR pointer, output stage and pend_mask logic live in the top module.

## Test plan
- Single write: p0 writes x5=0x1234 at cycle 0 → we3=1, wa3=5, wd3=0x1234 in cycle 2 only. pend_mask[5] is set in cycles 1–2 and clear in cycle 3.
- x0 drop: p1 writes x0=0xFFFF_FFFF → we3 stays 0 and pend_mask stays 0. p1_ready stays high.
- Contention, fixed priority: p0 writes x1=0xA and p1 writes x2=0xB in the same cycle → x1 written in cycle 2 and x2 in cycle 3. With p0 continuous for 5 cycles, p1 is held until p0 stops (p1_ready=0 throughout).
- Round-robin (WB_ARB_RR_EN): both ports stream writes every cycle → we3 alternates p0, p1, p0, p1 with no idle cycle, and each port's ready toggles accordingly.
- Same index: p0 x7=0x1 and p1 x7=0x2 simultaneously, fixed priority → a we3 pulse with 0x1, then one with 0x2. The register file ends with x7=0x2, and pend_mask[7] stays set until the second pulse.
- Reset mid-flight: reset asserted the cycle after both buffers load → no we3 pulse, all outputs zero, ready low during reset. The first accept after deassert completes with 2-cycle latency.
